// File: rtl/uart_pkg.sv
// uart_pkg: shared byte and launch-state types for the uart transmit/receive side
package uart_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock circular FIFO with occupancy count; refuses push when full
module fifo_sync #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign rdata = mem_q[rd_q];

    // Pointer and occupancy update; a full FIFO refuses push even when popped the same cycle
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + DEPTH_LOG2'(do_push);
        rd_d    = rd_q + DEPTH_LOG2'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO that launches one tx_start per byte into uart_tx, paced by tx_busy
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          wdata,
    input  logic                wvalid,
    output logic                wready,
    output logic [7:0]          sdata,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic [DEPTH_LOG2:0] count,
    output logic                empty,
    output logic                overflow
);
    state_t state_q, state_d;
    byte_t  sdata_q, sdata_d, rdata;
    logic   tx_start_q, tx_start_d, overflow_q, overflow_d;
    logic   full, pop;

    assign wready   = !full && !rst;
    assign sdata    = sdata_q;
    assign tx_start = tx_start_q;
    assign overflow = overflow_q;

    fifo_sync #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wvalid && wready),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Launch FSM: pop and pulse from idle, then wait for uart_tx busy to rise and fall
    always_comb begin
        state_d    = state_q;
        sdata_d    = sdata_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        overflow_d = overflow_q || (wvalid && !wready);
        case (state_q)
            S_IDLE: if (!empty && !tx_busy) begin
                pop        = 1'b1;
                sdata_d    = rdata;
                tx_start_d = 1'b1;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (tx_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM, output byte, launch pulse and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sdata_q    <= '0;
            tx_start_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sdata_q    <= sdata_d;
            tx_start_q <= tx_start_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed table and sequence checks with a behavioural uart_tx busy model
module tb_uart_tx_buffer;
    import uart_pkg::*;

    localparam int FRAME = 80;

    typedef struct {
        byte_t      wdata;
        logic [4:0] exp_cnt;
        byte_t      exp_sdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       wvalid = 1'b0;
    logic       wready, tx_start, tx_busy, empty, overflow;
    logic [7:0] sdata;
    logic [4:0] count;

    int    checks = 0;
    int    failures = 0;
    int    launches = 0;
    int    cnt = 0;
    logic  prev_start = 1'b0;
    byte_t exp_q[$];
    byte_t sent_q[$];

    uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .sdata    (sdata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .count    (count),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    assign tx_busy = cnt != 0;

    // uart_tx stand-in: busy rises the cycle after tx_start and holds for one frame
    initial forever begin
        @(posedge clk);
        if (rst) begin
            cnt        <= 0;
            prev_start <= 1'b0;
        end else begin
            prev_start <= tx_start;
            if (tx_start) begin
                checks++;
                if (tx_busy || prev_start) begin
                    failures++;
                    $display("FAIL start_guard busy=%0b prev_start=%0b required busy=0 prev_start=0", tx_busy, prev_start);
                end
                launches++;
                sent_q.push_back(sdata);
                cnt <= FRAME;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input byte_t b);
        wdata  = b;
        wvalid = 1'b1;
        if (wready) exp_q.push_back(b);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic wr_wait(input byte_t b);
        int n = 0;
        while (!wready && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("wready_timeout", 32'(n), 0);
        wr(b);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((!empty || tx_busy || tx_start) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) chk({name, "_drain_timeout"}, 32'(n), 0);
        chk({name, "_nsent"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < sent_q.size() && i < exp_q.size(); i++)
            chk({name, "_byte"}, 32'(sent_q[i]), 32'(exp_q[i]));
        sent_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tbl[5];
        int   l0, peak;
        tbl[0] = '{8'h41, 5'd1, 8'h41};
        tbl[1] = '{8'h00, 5'd1, 8'h00};
        tbl[2] = '{8'hFF, 5'd1, 8'hFF};
        tbl[3] = '{8'hA5, 5'd1, 8'hA5};
        tbl[4] = '{8'h5A, 5'd1, 8'h5A};

        rst = 1'b1;
        tick();
        chk("rst_wready", 32'(wready), 0);
        tick();
        tick();
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_sdata", 32'(sdata), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_wready", 32'(wready), 1);
        tick();

        for (int i = 0; i < 5; i++) begin
            wr(tbl[i].wdata);
            chk("vec_count_after_write", 32'(count), 32'(tbl[i].exp_cnt));
            chk("vec_no_fallthrough", 32'(tx_start), 0);
            tick();
            chk("vec_tx_start", 32'(tx_start), 1);
            chk("vec_sdata", 32'(sdata), 32'(tbl[i].exp_sdata));
            chk("vec_count_after_launch", 32'(count), 0);
            tick();
            chk("vec_pulse_width", 32'(tx_start), 0);
            drain("vec");
        end

        l0 = launches;
        peak = 0;
        wr(8'h55); if (32'(count) > peak) peak = 32'(count);
        wr(8'hAA); if (32'(count) > peak) peak = 32'(count);
        wr(8'h00); if (32'(count) > peak) peak = 32'(count);
        wr(8'hFF); if (32'(count) > peak) peak = 32'(count);
        tick();    if (32'(count) > peak) peak = 32'(count);
        chk("burst_peak", 32'(peak), 3);
        drain("burst");
        chk("burst_launches", 32'(launches - l0), 4);

        l0 = launches;
        for (int i = 0; i < 18; i++) wr(byte_t'(8'h80 + i));
        chk("full_count", 32'(count), 16);
        chk("full_wready", 32'(wready), 0);
        chk("full_overflow", 32'(overflow), 1);
        chk("full_accepted", 32'(exp_q.size()), 17);
        drain("full");
        chk("full_launches", 32'(launches - l0), 17);

        wr(8'h10);
        chk("pp_count_before", 32'(count), 1);
        wr(8'h11);
        chk("pp_count_same", 32'(count), 1);
        chk("pp_tx_start", 32'(tx_start), 1);
        drain("pushpop");

        l0 = launches;
        for (int i = 0; i < 40; i++) wr_wait(byte_t'(i * 7 + 3));
        drain("wrap");
        chk("wrap_launches", 32'(launches - l0), 40);
        chk("overflow_sticky", 32'(overflow), 1);

        for (int i = 0; i < 6; i++) wr(byte_t'(8'hC0 + i));
        chk("mid_count", 32'(count), 5);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_tx_start", 32'(tx_start), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_wready", 32'(wready), 0);
        rst = 1'b0;
        exp_q.delete();
        sent_q.delete();
        l0 = launches;
        repeat (200) tick();
        chk("mid_no_launch", 32'(launches - l0), 0);
        chk("mid_overflow_cleared", 32'(overflow), 0);
        wr(8'h7E);
        drain("after_rst");
        chk("after_rst_launches", 32'(launches - l0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
